pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic register pipeline; the next generation of the team's 8-bit D register.
- Adds:
  - configurable data width and stage count
  - per-stage valid bits
  - valid/ready backpressure with bubble collapsing
  - synchronous flush
  - occupancy count
- Sits between datapath blocks that need retiming plus flow control.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every stage data register on reset or flush.

Ports:
- sclk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stages 0..DEPTH-1. Stage 0 takes input; stage DEPTH-1 drives outputs. Each stage has data[i] and v[i].
- Reset (rst_n=0 at edge):
  - all v[i]=0 and data[i]=RESET_VAL
  - occupancy=0, out_valid=0, out_data=RESET_VAL
  - in_ready=0 while rst_n=0
  - Reset mid-transfer drops all in-flight data; no partial outputs.
- Transfers:
  - Output transfer: out_valid && out_ready.
  - Input transfer: in_valid && in_ready.
- Advance rule, evaluated combinationally from last stage backward:
  - go[DEPTH-1] = out_ready || !v[DEPTH-1]
  - go[i] = go[i+1] || !v[i]
  - Stage i loads from stage i-1 (or in_data for i=0) when go[i]=1.
  - On load, v[i] takes v[i-1] (or in_valid&&in_ready for i=0).
  - Bubbles collapse: an empty stage always accepts.
- Ready path:
  - in_ready = go[0] && !flush && rst_n.
  - in_ready is combinational from out_ready; no registered ready is required.
- Latency:
  - Empty pipe: DEPTH cycles from input transfer to out_valid=1.
  - Throughput is 1 word/cycle when out_ready is held high.
- Hold: while a stage is stalled (go[i]=0), its data and valid are held unchanged. out_data is stable while out_valid && !out_ready.
- Flush (flush=1 at edge, rst_n=1):
  - all v[i]=0 and data[i]=RESET_VAL
  - in_ready=0 that cycle
  - an output transfer in the same cycle still completes downstream (data was presented)
  - flush has priority over any load
- Occupancy:
  - Registered count of set v[i].
  - Next value = occupancy + in_xfer − out_xfer.
  - Forced to 0 on reset or flush.
  - Range 0..DEPTH; never wraps.
- Full/empty boundaries:
  - With occupancy=DEPTH and out_ready=0: in_ready=0.
  - With occupancy=DEPTH and out_ready=1: in_ready=1, so simultaneous in/out transfer keeps occupancy=DEPTH.
  - With occupancy=0: out_valid=0 and out_data=RESET_VAL.
- DEPTH=1 degenerates to a single register with the same rules.

Optional Feature:
- Macro: PIPE_REG_PARITY_EN.
- Defined:
  - Each stage stores an even-parity bit computed from in_data at stage 0 and carried with the data.
  - Extra output par_err (1 bit, registered) is set for one cycle when out_valid=1 and the recomputed parity of out_data mismatches the carried bit.
  - par_err is 0 on reset and flush.
- Not defined: no parity storage and no par_err port; behaviour is otherwise identical.

Test Plan:
- Reset, WIDTH=8, DEPTH=4, RESET_VAL=0: rst_n=0 for 2 cycles -> out_valid=0, out_data=0x00, occupancy=0, in_ready=0; after release in_ready=1.
- Streaming: push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_valid rises 4 cycles after first accept; 0x11,0x22,0x33 appear on consecutive cycles; occupancy peaks at 3.
- Full/backpressure: out_ready=0, push 5 words 0xA0..0xA4 -> first 4 accepted, occupancy=4, in_ready=0 on the 5th; out_data holds 0xA0. Raise out_ready -> drains 0xA0..0xA3 in order, 0xA4 accepted the same cycle drain starts.
- Simultaneous in/out at full: occupancy=4, out_ready=1, in_valid=1 -> occupancy stays 4 and in_ready=1 every cycle.
- Flush mid-stream: 3 words in flight, flush=1 for 1 cycle -> next cycle occupancy=0, out_valid=0, in_ready=0 during the flush cycle; a later push of 0x55 emerges after 4 cycles.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02, out_ready=0 -> both end in stages 3 and 2 (adjacent), occupancy=2; with PIPE_REG_PARITY_EN, forcing a parity-bit flip in stage 3 gives par_err=1.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register pipeline: valid/ready with bubble collapsing, sync flush, occupancy; latency DEPTH when empty.
// in_ready is combinational from out_ready (no registered ready). Define PIPE_REG_PARITY_EN for carried parity and par_err.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_REG_PARITY_EN
  ,
  output logic                         par_err
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_d   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] v_q, v_d, src_v, go;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             clear, in_xfer, out_xfer, go_acc;

  assign clear    = !rst_n || flush;
  assign in_ready = go[0] && !flush && rst_n;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = v_q[DEPTH-1] && out_ready;

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    go_acc      = out_ready || !v_q[DEPTH-1];
    go          = '0;
    go[DEPTH-1] = go_acc;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      go_acc = go_acc || !v_q[i];
      go[i]  = go_acc;
    end
  end

  always_comb begin
    src_v       = '0;
    src_v[0]    = in_xfer;
    src_data[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_v[i]    = v_q[i-1];
      src_data[i] = data_q[i-1];
    end
  end

  // Empty stages always hold RESET_VAL, so out_data is RESET_VAL whenever out_valid is low.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      data_d[i] = data_q[i];
      if (clear) begin
        data_d[i] = RESET_VAL;
        v_d[i]    = 1'b0;
      end else if (go[i]) begin
        v_d[i]    = src_v[i];
        data_d[i] = src_v[i] ? src_data[i] : RESET_VAL;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (clear) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  always_ff @(posedge sclk) begin
    data_q <= data_d;
    v_q    <= v_d;
    occ_q  <= occ_d;
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_REG_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d, src_par;
  logic             par_err_q, par_err_d;

  always_comb begin
    src_par    = '0;
    src_par[0] = ^in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_par[i] = par_q[i-1];
    end
  end

  // Parity travels exactly like the data it protects; the check uses the last stage.
  always_comb begin
    par_d = par_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (clear) begin
        par_d[i] = 1'b0;
      end else if (go[i]) begin
        par_d[i] = src_v[i] && src_par[i];
      end
    end
    par_err_d = !clear && v_q[DEPTH-1] && ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);
  end

  always_ff @(posedge sclk) begin
    par_q     <= par_d;
    par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=8, DEPTH=4): directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based timing model.
module tb_pipe_reg_chain;
  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'h00;

  logic       sclk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 sclk = ~sclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Model: words in flight in order, each tagged with its accept cycle. A word reaches the
  // output DEPTH cycles after acceptance, but never before the cycle after its predecessor left.
  typedef struct {
    logic [7:0] d;
    int         t;
  } item_t;

  item_t      q[$];
  int         cyc      = 0;
  int         last_out = -1000;
  logic       exp_valid, exp_ready;
  logic [7:0] exp_data;

  initial begin
    @(posedge sclk);
    forever begin
      @(negedge sclk);
      exp_ready = rst_n && !flush && (out_ready || q.size() < D);
      exp_valid = (q.size() > 0) && (cyc >= q[0].t + D) && (cyc > last_out);
      exp_data  = exp_valid ? q[0].d : RV;
      check("m_in_ready",  in_ready,  exp_ready);
      check("m_out_valid", out_valid, exp_valid);
      check("m_out_data",  out_data,  exp_data);
      check("m_occupancy", occupancy, q.size());
      if (!rst_n || flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) begin
          void'(q.pop_front());
          last_out = cyc;
        end
        if (in_valid && exp_ready) q.push_back('{d: in_data, t: cyc});
      end
      cyc++;
    end
  end

  initial begin
    logic [7:0] sv [3];
    int         or_pct;
    sv = '{8'h11, 8'h22, 8'h33};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

    // Reset
    tick(); tick();
    @(negedge sclk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready",  in_ready,  0);
    tick();
    rst_n = 1'b1;
    @(negedge sclk);
    check("rel_in_ready", in_ready, 1);

    // Streaming
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); in_valid = 1'b1; in_data = sv[k];
    end
    tick(); in_valid = 1'b0;
    @(negedge sclk);
    check("str_not_yet_valid", out_valid, 0);
    check("str_occ_peak",      occupancy, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge sclk);
      check("str_out_valid", out_valid, 1);
      check("str_out_data",  out_data,  sv[k]);
    end
    tick();
    @(negedge sclk);
    check("str_done_valid", out_valid, 0);
    check("str_done_occ",   occupancy, 0);

    // Full / backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(); in_valid = 1'b1; in_data = 8'(8'hA0 + k);
    end
    @(negedge sclk);
    check("full_in_ready", in_ready,  0);
    check("full_occ",      occupancy, 4);
    check("full_out_data", out_data,  8'hA0);
    tick();
    @(negedge sclk);
    check("hold_out_data", out_data, 8'hA0);
    check("hold_in_ready", in_ready, 0);
    tick(); out_ready = 1'b1;
    @(negedge sclk);
    check("drain_in_ready", in_ready, 1);
    check("drain_out_data", out_data, 8'hA0);
    tick(); in_valid = 1'b0;
    @(negedge sclk);
    check("drain_out_data", out_data, 8'hA1);
    for (int k = 2; k < 5; k++) begin
      tick();
      @(negedge sclk);
      check("drain_out_data", out_data, 8'hA0 + k);
    end
    tick();
    @(negedge sclk);
    check("drain_empty_occ", occupancy, 0);

    // Simultaneous in/out at full
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); in_valid = 1'b1; in_data = 8'(8'hB0 + k);
    end
    tick(); out_ready = 1'b1; in_data = 8'hB4;
    @(negedge sclk);
    check("sim_out_data", out_data, 8'hB0);
    for (int k = 5; k < 10; k++) begin
      @(negedge sclk);
      check("sim_in_ready", in_ready,  1);
      check("sim_occ",      occupancy, 4);
      tick(); in_data = 8'(8'hB0 + k);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge sclk);
    check("sim_drained_occ", occupancy, 0);

    // Flush mid-stream
    for (int k = 0; k < 3; k++) begin
      tick(); in_valid = 1'b1; in_data = 8'(8'hC0 + k);
    end
    tick(); flush = 1'b1; in_data = 8'h77;
    @(negedge sclk);
    check("flush_in_ready", in_ready,  0);
    check("flush_occ_pre",  occupancy, 3);
    tick(); flush = 1'b0; in_data = 8'h55;
    @(negedge sclk);
    check("flush_occ",       occupancy, 0);
    check("flush_out_valid", out_valid, 0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    @(negedge sclk);
    check("flush_55_early", out_valid, 0);
    tick();
    @(negedge sclk);
    check("flush_55_valid", out_valid, 1);
    check("flush_55_data",  out_data,  8'h55);

    // Bubble collapse
    tick(); out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick(); in_valid = 1'b0;
    tick();
    tick(); in_valid = 1'b1; in_data = 8'h02;
    tick(); in_valid = 1'b0;
    repeat (5) tick();
    @(negedge sclk);
    check("bub_occ",      occupancy, 2);
    check("bub_out_data", out_data,  8'h01);
    tick(); out_ready = 1'b1;
    @(negedge sclk);
    check("bub_first", out_data, 8'h01);
    tick();
    @(negedge sclk);
    check("bub_second_valid", out_valid, 1);
    check("bub_second_data",  out_data,  8'h02);
    tick();
    @(negedge sclk);
    check("bub_empty", out_valid, 0);

    // Randomized traffic with varying downstream pressure, occasional flush and reset
    for (int blk = 0; blk < 20; blk++) begin
      or_pct = int'($urandom_range(100, 10));
      for (int c = 0; c < 200; c++) begin
        tick();
        in_valid  = ($urandom_range(99) < 70);
        in_data   = 8'($urandom);
        out_ready = (int'($urandom_range(99)) < or_pct);
        flush     = ($urandom_range(99) < 2);
        rst_n     = !($urandom_range(999) < 4);
      end
    end
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    @(negedge sclk);
    check("final_occ", occupancy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
